// File: rtl/wf68k_30l_top.sv
// Minimal 68030-style bus master. It runs an asynchronous bus cycle
// (S1 address, S2 strobes and waits, recovery) and executes a small
// subset of instructions: NOP, MOVEQ, MOVE #imm/Dn to (xxx).L and BRA.
module wf68k_30l_top #(
  parameter int unsigned NO_PIPELINE = 0,
  parameter int unsigned NO_LOOP     = 0
) (
  input  logic        CLK,
  input  logic        RESET_IN,
  output logic [31:0] ADR_OUT,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        DATA_EN,
  output logic        BUS_EN,
  input  logic        BERRn,
  input  logic        HALT_INn,
  output logic        HALT_OUTn,
  output logic        RESET_OUT,
  output logic [2:0]  FC_OUT,
  input  logic        AVECn,
  input  logic [2:0]  IPLn,
  output logic        IPENDn,
  input  logic [1:0]  DSACKn,
  input  logic        STERMn,
  output logic [1:0]  SIZE,
  output logic        ASn,
  output logic        DSn,
  output logic        ECSn,
  output logic        OCSn,
  output logic        DBENn,
  output logic        RWn,
  output logic        RMCn,
  output logic        STATUSn,
  output logic        REFILLn,
  input  logic        BRn,
  output logic        BGn,
  input  logic        BGACKn
);

  typedef enum logic [2:0] {BusIdle, BusS1, BusS2, BusRec, BusGrant} bus_st_e;
  typedef enum logic [2:0] {CtlVecSp, CtlVecPc, CtlOp, CtlExt, CtlWrite, CtlHalt} ctl_st_e;

  localparam logic [1:0] SzByte = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;
  localparam logic [1:0] SzLong = 2'b00;
  localparam logic [2:0] FcProg = 3'b110;
  localparam logic [2:0] FcData = 3'b101;

  bus_st_e     bus_st_q, bus_st_d;
  ctl_st_e     ctl_st_q, ctl_st_d;
  logic [31:0] adr_q, adr_d;
  logic [1:0]  size_q, size_d;
  logic        rw_q, rw_d;
  logic [2:0]  fc_q, fc_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] a7_q, a7_d;
  logic [31:0] d_q [8];
  logic [31:0] d_d [8];
  logic [15:0] op_q, op_d;
  logic [47:0] ext_q, ext_d;
  logic [2:0]  ext_left_q, ext_left_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] val_q, val_d;

  logic        term;
  logic        idle_ack;
  logic [31:0] rd_val;
  logic [15:0] w;
  logic [63:0] nb;
  logic [31:0] req_adr;
  logic [1:0]  req_size;
  logic        req_rw;
  logic [2:0]  req_fc;
  logic [31:0] req_data;
  logic        req_aerr;
  logic [1:0]  mv_size;

  function automatic logic is_move(input logic [15:0] op);
    return (op[15:14] == 2'b00) && (op[13:12] != 2'b00) && (op[11:6] == 6'b001111) &&
           ((op[5:0] == 6'b111100) || (op[5:3] == 3'b000));
  endfunction

  // Every acknowledge is treated as a 32-bit port.
  assign term     = (DSACKn != 2'b11) || !STERMn;
  assign idle_ack = (DSACKn == 2'b11) && STERMn;
  assign w        = rd_val[15:0];
  // Extension words shift in from the right; the newest word is the low half.
  assign nb       = {ext_q, w};
  assign mv_size  = (op_q[13:12] == 2'b01) ? SzByte :
                    (op_q[13:12] == 2'b11) ? SzWord : SzLong;

  // Read lane select for the latched address and size.
  always_comb begin
    rd_val = DATA_IN;
    if (size_q == SzByte) begin
      unique case (adr_q[1:0])
        2'b00:   rd_val = {24'h0, DATA_IN[31:24]};
        2'b01:   rd_val = {24'h0, DATA_IN[23:16]};
        2'b10:   rd_val = {24'h0, DATA_IN[15:8]};
        default: rd_val = {24'h0, DATA_IN[7:0]};
      endcase
    end else if (size_q == SzWord) begin
      rd_val = adr_q[1] ? {16'h0, DATA_IN[15:0]} : {16'h0, DATA_IN[31:16]};
    end
  end

  // Parameters of the next bus cycle the control sequencer wants.
  always_comb begin
    req_adr  = pc_q;
    req_size = SzWord;
    req_rw   = 1'b1;
    req_fc   = FcProg;
    req_data = '0;
    unique case (ctl_st_q)
      CtlVecSp: begin req_adr = 32'h0; req_size = SzLong; req_fc = FcData; end
      CtlVecPc: begin req_adr = 32'h4; req_size = SzLong; req_fc = FcData; end
      CtlWrite: begin
        req_adr  = ea_q;
        req_size = mv_size;
        req_rw   = 1'b0;
        req_fc   = FcData;
        unique case (mv_size)
          SzByte:  req_data = {4{val_q[7:0]}};
          SzWord:  req_data = {2{val_q[15:0]}};
          default: req_data = val_q;
        endcase
      end
      default: ;
    endcase
    req_aerr = ((req_size == SzWord) && req_adr[0]) ||
               ((req_size == SzLong) && (req_adr[1:0] != 2'b00));
  end

  // Next state for the bus cycle and the instruction sequencer.
  always_comb begin
    bus_st_d   = bus_st_q;
    ctl_st_d   = ctl_st_q;
    adr_d      = adr_q;
    size_d     = size_q;
    rw_d       = rw_q;
    fc_d       = fc_q;
    dout_d     = dout_q;
    pc_d       = pc_q;
    a7_d       = a7_q;
    d_d        = d_q;
    op_d       = op_q;
    ext_d      = ext_q;
    ext_left_d = ext_left_q;
    ea_d       = ea_q;
    val_d      = val_q;
    unique case (bus_st_q)
      BusIdle: begin
        if (!BRn) begin
          bus_st_d = BusGrant;
        end else if ((ctl_st_q != CtlHalt) && HALT_INn) begin
          if (req_aerr) begin
            ctl_st_d = CtlHalt;
          end else begin
            bus_st_d = BusS1;
            adr_d    = req_adr;
            size_d   = req_size;
            rw_d     = req_rw;
            fc_d     = req_fc;
            dout_d   = req_data;
          end
        end
      end
      BusS1: bus_st_d = BusS2;
      BusS2: begin
        if (term) begin
          bus_st_d = BusRec;
          if (!BERRn) begin
            ctl_st_d = CtlHalt;
          end else begin
            case (ctl_st_q)
              CtlVecSp: begin a7_d = rd_val; ctl_st_d = CtlVecPc; end
              CtlVecPc: begin pc_d = rd_val; ctl_st_d = CtlOp; end
              CtlOp: begin
                pc_d = pc_q + 32'd2;
                op_d = w;
                if (w == 16'h4E71) begin
                  ctl_st_d = CtlOp;
                end else if ((w[15:12] == 4'h7) && !w[8]) begin
                  d_d[w[11:9]] = {{24{w[7]}}, w[7:0]};
                end else if (w[15:8] == 8'h60) begin
                  if (w[7:0] == 8'h00) begin
                    ext_left_d = 3'd1;
                    ctl_st_d   = CtlExt;
                  end else begin
                    pc_d = pc_q + 32'd2 + {{24{w[7]}}, w[7:0]};
                  end
                end else if (is_move(w)) begin
                  ext_left_d = (w[5:3] == 3'b000) ? 3'd2 : (w[13:12] == 2'b10) ? 3'd4 : 3'd3;
                  ctl_st_d   = CtlExt;
                end else begin
                  ctl_st_d = CtlHalt;
                end
              end
              CtlExt: begin
                pc_d       = pc_q + 32'd2;
                ext_d      = nb[47:0];
                ext_left_d = ext_left_q - 3'd1;
                if (ext_left_q == 3'd1) begin
                  if (op_q[15:8] == 8'h60) begin
                    // pc_q is the extension word address, i.e. opcode address + 2.
                    pc_d     = pc_q + {{16{w[15]}}, w};
                    ctl_st_d = CtlOp;
                  end else begin
                    ea_d = nb[31:0];
                    if (op_q[5:3] == 3'b000) val_d = d_q[op_q[2:0]];
                    else if (op_q[13:12] == 2'b10) val_d = nb[63:32];
                    else val_d = {16'h0, nb[47:32]};
                    ctl_st_d = CtlWrite;
                  end
                end
              end
              CtlWrite: ctl_st_d = CtlOp;
              default: ;
            endcase
          end
        end
      end
      // Wait for the slave to withdraw its acknowledge before idling.
      BusRec:   if (idle_ack) bus_st_d = BusIdle;
      BusGrant: if (BRn && BGACKn) bus_st_d = BusIdle;
      default:  bus_st_d = BusIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET_IN) begin
      bus_st_q   <= BusIdle;
      ctl_st_q   <= CtlVecSp;
      adr_q      <= '0;
      size_q     <= SzLong;
      rw_q       <= 1'b1;
      fc_q       <= FcData;
      dout_q     <= '0;
      pc_q       <= '0;
      a7_q       <= '0;
      for (int i = 0; i < 8; i++) d_q[i] <= '0;
      op_q       <= '0;
      ext_q      <= '0;
      ext_left_q <= '0;
      ea_q       <= '0;
      val_q      <= '0;
    end else begin
      bus_st_q   <= bus_st_d;
      ctl_st_q   <= ctl_st_d;
      adr_q      <= adr_d;
      size_q     <= size_d;
      rw_q       <= rw_d;
      fc_q       <= fc_d;
      dout_q     <= dout_d;
      pc_q       <= pc_d;
      a7_q       <= a7_d;
      d_q        <= d_d;
      op_q       <= op_d;
      ext_q      <= ext_d;
      ext_left_q <= ext_left_d;
      ea_q       <= ea_d;
      val_q      <= val_d;
    end
  end

  // Bus outputs; reset forces them idle at once so a cycle aborts immediately.
  always_comb begin
    ASn       = 1'b1;
    DSn       = 1'b1;
    DBENn     = 1'b1;
    ECSn      = 1'b1;
    OCSn      = 1'b1;
    DATA_EN   = 1'b0;
    ADR_OUT   = '0;
    DATA_OUT  = '0;
    SIZE      = SzLong;
    RWn       = 1'b1;
    FC_OUT    = FcData;
    BGn       = 1'b1;
    BUS_EN    = 1'b1;
    HALT_OUTn = 1'b1;
    if (!RESET_IN) begin
      ECSn      = (bus_st_q != BusS1);
      OCSn      = (bus_st_q != BusS1);
      ASn       = (bus_st_q != BusS2);
      DSn       = (bus_st_q != BusS2);
      DBENn     = (bus_st_q != BusS2);
      DATA_EN   = (bus_st_q == BusS2) && !rw_q;
      ADR_OUT   = adr_q;
      DATA_OUT  = dout_q;
      SIZE      = size_q;
      RWn       = rw_q;
      FC_OUT    = fc_q;
      BGn       = (bus_st_q != BusGrant);
      BUS_EN    = (bus_st_q != BusGrant);
      HALT_OUTn = (ctl_st_q != CtlHalt);
    end
  end

  assign IPENDn    = (IPLn == 3'b111);
  assign RESET_OUT = 1'b0;
  assign RMCn      = 1'b1;
  assign STATUSn   = 1'b1;
  assign REFILLn   = 1'b1;

  // A7, autovector input and the mode parameters have no effect on behaviour.
  logic unused_sig;
  assign unused_sig = ^{AVECn, a7_q, op_q, NO_PIPELINE != 0, NO_LOOP != 0};

endmodule

// File: tb/tb_wf68k_30l_top.sv
// Bench for wf68k_30l_top: memory/acknowledge model, expected bus cycles in
// a scoreboard queue, and a monitor that checks each cycle as it starts.
module tb_wf68k_30l_top;

  logic        CLK = 1'b0;
  logic        RESET_IN = 1'b1;
  logic [31:0] ADR_OUT, DATA_OUT;
  logic [31:0] DATA_IN = '0;
  logic        DATA_EN, BUS_EN, HALT_OUTn, RESET_OUT, IPENDn;
  logic        BERRn = 1'b1, HALT_INn = 1'b1, AVECn = 1'b1, STERMn = 1'b1;
  logic        BRn = 1'b1, BGACKn = 1'b1;
  logic [2:0]  IPLn = 3'b111;
  logic [1:0]  DSACKn = 2'b11;
  logic [2:0]  FC_OUT;
  logic [1:0]  SIZE;
  logic        ASn, DSn, ECSn, OCSn, DBENn, RWn, RMCn, STATUSn, REFILLn, BGn;

  wf68k_30l_top #(.NO_PIPELINE(0), .NO_LOOP(0)) dut (
    .CLK(CLK), .RESET_IN(RESET_IN), .ADR_OUT(ADR_OUT), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .DATA_EN(DATA_EN), .BUS_EN(BUS_EN), .BERRn(BERRn),
    .HALT_INn(HALT_INn), .HALT_OUTn(HALT_OUTn), .RESET_OUT(RESET_OUT), .FC_OUT(FC_OUT),
    .AVECn(AVECn), .IPLn(IPLn), .IPENDn(IPENDn), .DSACKn(DSACKn), .STERMn(STERMn),
    .SIZE(SIZE), .ASn(ASn), .DSn(DSn), .ECSn(ECSn), .OCSn(OCSn), .DBENn(DBENn),
    .RWn(RWn), .RMCn(RMCn), .STATUSn(STATUSn), .REFILLn(REFILLn), .BRn(BRn),
    .BGn(BGn), .BGACKn(BGACKn)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] adr;
    logic [1:0]  size;
    logic        rw;
    logic [2:0]  fc;
    logic [31:0] dat;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          n_cycles = 0;
  logic [31:0] mem [0:63];
  logic [31:0] slow_adr = 32'hFFFF_FFFF;
  int          slow_wait = 0;
  logic [31:0] berr_adr = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    sb.push_back('{adr: a, size: 2'b10, rw: 1'b1, fc: 3'b110, dat: 32'h0, waits: 0});
  endtask

  task automatic exp_vec(input logic [31:0] a);
    sb.push_back('{adr: a, size: 2'b00, rw: 1'b1, fc: 3'b101, dat: 32'h0, waits: 0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                        input int wt);
    sb.push_back('{adr: a, size: s, rw: 1'b0, fc: 3'b101, dat: d, waits: wt});
  endtask

  task automatic put_w(input logic [31:0] a, input logic [15:0] v);
    if (a[1]) mem[a[7:2]][15:0] = v;
    else mem[a[7:2]][31:16] = v;
  endtask

  task automatic wait_empty(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Hold reset, load the vector table, leave reset asserted for the caller.
  task automatic start_reset();
    RESET_IN = 1'b1;
    tick(3);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_1000;
    mem[1] = 32'h0000_0008;
    exp_vec(32'h0);
    exp_vec(32'h4);
  endtask

  // Slave: acknowledges as a 32-bit port after the programmed wait states.
  int s2cnt = 0;
  always @(negedge CLK) begin
    if (!ASn) begin
      if (s2cnt >= ((ADR_OUT == slow_adr) ? slow_wait : 0)) begin
        DSACKn  = 2'b00;
        DATA_IN = mem[ADR_OUT[7:2]];
        BERRn   = (ADR_OUT == berr_adr) ? 1'b0 : 1'b1;
      end
      s2cnt++;
    end else begin
      DSACKn = 2'b11;
      BERRn  = 1'b1;
      s2cnt  = 0;
    end
  end

  // Monitor: compares each cycle's S2 against the next expected entry.
  logic prev_as = 1'b1;
  int   as_len = 0;
  int   ecs_run = 0;
  logic have_cur = 1'b0;
  exp_t cur;
  always @(negedge CLK) begin
    if (ASn && !ECSn) ecs_run++;
    if (prev_as && !ASn) begin
      n_cycles++;
      as_len = 0;
      if (sb.size() == 0) begin
        total++;
        bad++;
        have_cur = 1'b0;
        $display("FAIL unexpected_cycle: got adr %h expected no cycle", ADR_OUT);
      end else begin
        cur = sb.pop_front();
        have_cur = 1'b1;
        check("adr", ADR_OUT, cur.adr);
        check("size", 32'(SIZE), 32'(cur.size));
        check("rwn", 32'(RWn), 32'(cur.rw));
        check("fc", 32'(FC_OUT), 32'(cur.fc));
        check("ecs_one_clock", 32'(ecs_run), 32'd1);
        check("ds_dben", 32'({DSn, DBENn}), 32'd0);
        if (!cur.rw) begin
          check("data_en", 32'(DATA_EN), 32'd1);
          check("data_out", DATA_OUT, cur.dat);
        end
      end
      ecs_run = 0;
    end
    if (!ASn) as_len++;
    if (!prev_as && ASn && have_cur) begin
      check("as_len", 32'(as_len), 32'(cur.waits + 1));
      have_cur = 1'b0;
    end
    prev_as = ASn;
  end

  logic [15:0] prog1 [24];
  int          snap;

  initial begin
    prog1 = '{16'h13FC, 16'h0048, 16'h0000, 16'h0100,
              16'h7041,
              16'h33C0, 16'h0000, 16'h0102,
              16'h23FC, 16'h1234, 16'h5678, 16'h0000, 16'h0104,
              16'h4E71, 16'h6002, 16'hFFFF, 16'h6000, 16'h0004, 16'hFFFF, 16'h7080,
              16'h13C0, 16'h0000, 16'h0110,
              16'h60FE};

    // Phase 1: reset state, then the straight-line program and branch loop.
    start_reset();
    check("rst_strobes", 32'({ASn, DSn, ECSn, OCSn, DBENn, RWn, RMCn}), 32'h7F);
    check("rst_adr", ADR_OUT, 32'h0);
    check("rst_dout", DATA_OUT, 32'h0);
    check("rst_misc", 32'({DATA_EN, SIZE, FC_OUT, BUS_EN, BGn, HALT_OUTn, RESET_OUT}),
          32'b0_00_101_1110);
    check("ipend_idle", 32'(IPENDn), 32'd1);
    IPLn = 3'b101;
    #1;
    check("ipend_req", 32'(IPENDn), 32'd0);
    IPLn = 3'b111;
    for (int i = 0; i < 24; i++) put_w(32'(8 + 2 * i), prog1[i]);
    slow_adr  = 32'h104;
    slow_wait = 5;
    for (int a = 8; a <= 14; a += 2) exp_fetch(32'(a));
    exp_wr(32'h100, 2'b01, 32'h4848_4848, 0);
    exp_fetch(32'h10);
    for (int a = 16'h12; a <= 16'h16; a += 2) exp_fetch(32'(a));
    exp_wr(32'h102, 2'b10, 32'h0041_0041, 0);
    for (int a = 16'h18; a <= 16'h20; a += 2) exp_fetch(32'(a));
    exp_wr(32'h104, 2'b00, 32'h1234_5678, 5);
    exp_fetch(32'h22);
    exp_fetch(32'h24);
    exp_fetch(32'h28);
    exp_fetch(32'h2A);
    exp_fetch(32'h2E);
    for (int a = 16'h30; a <= 16'h34; a += 2) exp_fetch(32'(a));
    exp_wr(32'h110, 2'b01, 32'h8080_8080, 0);
    for (int i = 0; i < 3; i++) exp_fetch(32'h36);
    RESET_IN = 1'b0;
    wait_empty(600);

    // Stall before the next S1, then bus arbitration.
    HALT_INn = 1'b0;
    snap = n_cycles;
    tick(12);
    check("halt_in_stall", 32'(n_cycles), 32'(snap));
    check("halt_in_as", 32'(ASn), 32'd1);
    BRn = 1'b0;
    tick(2);
    check("grant", 32'({BGn, BUS_EN, ASn}), 32'b001);
    BRn    = 1'b1;
    BGACKn = 1'b0;
    tick(3);
    check("grant_held_bgack", 32'({BGn, BUS_EN}), 32'b00);
    BGACKn = 1'b1;
    tick(2);
    check("grant_released", 32'({BGn, BUS_EN}), 32'b11);
    exp_fetch(32'h36);
    exp_fetch(32'h36);
    HALT_INn = 1'b1;
    wait_empty(100);
    RESET_IN = 1'b1;
    #1;
    check("reset_abort", 32'({ASn, DSn, DBENn}), 32'b111);
    slow_adr  = 32'hFFFF_FFFF;
    slow_wait = 0;

    // Phase 2: illegal opcode halts.
    start_reset();
    put_w(32'h8, 16'hFFFF);
    exp_fetch(32'h8);
    RESET_IN = 1'b0;
    wait_empty(100);
    snap = n_cycles;
    tick(20);
    check("illegal_halt", 32'(HALT_OUTn), 32'd0);
    check("illegal_no_as", 32'(n_cycles), 32'(snap));

    // Phase 3: bus error on the first fetch halts; reset clears the halt.
    start_reset();
    check("reset_clears_halt", 32'(HALT_OUTn), 32'd1);
    put_w(32'h8, 16'h4E71);
    berr_adr = 32'h8;
    exp_fetch(32'h8);
    RESET_IN = 1'b0;
    wait_empty(100);
    snap = n_cycles;
    tick(20);
    check("berr_halt", 32'(HALT_OUTn), 32'd0);
    check("berr_no_as", 32'(n_cycles), 32'(snap));
    berr_adr = 32'hFFFF_FFFF;

    // Phase 4: MOVE.W to an odd address is an address error, no write cycle.
    start_reset();
    put_w(32'h8, 16'h33FC);
    put_w(32'hA, 16'h1111);
    put_w(32'hC, 16'h0000);
    put_w(32'hE, 16'h0101);
    for (int a = 8; a <= 14; a += 2) exp_fetch(32'(a));
    RESET_IN = 1'b0;
    wait_empty(100);
    snap = n_cycles;
    tick(20);
    check("aerr_halt", 32'(HALT_OUTn), 32'd0);
    check("aerr_no_write", 32'(n_cycles), 32'(snap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wf68k_30l_top.md
WF68K_30L_TOP -- requirements
Module: wf68k_30l_top

Interface
REQ-001 SHALL have parameters NO_PIPELINE (default 0) and NO_LOOP (default 0), both accepted and functionally inert in this core.
REQ-002 SHALL have one clock and a synchronous, active-high reset: CLK in 1 (all logic on rising edge); RESET_IN in 1 (synchronous, active-high).
REQ-003 SHALL have ADR_OUT out 32 (byte address), DATA_IN in 32 (read data) and DATA_OUT out 32 (write data).
REQ-004 SHALL have DATA_EN out 1 (high while DATA_OUT driven) and BUS_EN out 1 (high while the core owns the bus).
REQ-005 SHALL have BERRn in 1 (bus error), HALT_INn in 1 (stall request), HALT_OUTn out 1 (low = halted) and RESET_OUT out 1 (held 0).
REQ-006 SHALL have FC_OUT out 3 (110 program fetch, 101 data), AVECn in 1 (ignored), IPLn in 3 and IPENDn out 1 (low when IPLn != 111).
REQ-007 SHALL have DSACKn in 2 and STERMn in 1 (cycle terminators), plus SIZE out 2 (01 byte, 10 word, 00 long).
REQ-008 SHALL have ASn, DSn, ECSn, OCSn and DBENn out 1 each (active-low strobes), RWn out 1 (1 = read) and RMCn out 1 (held 1).
REQ-009 SHALL have STATUSn and REFILLn out 1 (held 1), and BRn in, BGn out and BGACKn in, each 1 bit (bus arbitration).

Function
REQ-010 Bus cycle, clock S1 SHALL drive ADR_OUT, SIZE, RWn, FC_OUT and pull ECSn/OCSn low for exactly one clock.
REQ-011 From S2, ASn, DSn and DBENn SHALL be low, with DATA_OUT/DATA_EN valid on writes; unlimited wait states while DSACKn==11 and STERMn==1.
REQ-012 Termination on the first edge with DSACKn!=11 or STERMn==0 SHALL latch DATA_IN on reads; every acknowledge is treated as a 32-bit port.
REQ-013 The clock after termination, ASn/DSn/DBENn SHALL go high and DATA_EN=0; no new cycle may start until DSACKn==11 and STERMn==1.
REQ-014 Read lanes: byte SHALL be taken from DATA_IN lane A[1:0] (00=31:24 ... 11=7:0), word from 31:16 if A[1]=0 else 15:0, long as-is.
REQ-015 Write lanes: byte replicated on all four lanes, word replicated on both halves, long unmodified.
REQ-016 Word at odd address or long at A[1:0]!=00 SHALL be an address error (halt, REQ-021).
REQ-017 After reset: long read at 0 loads A7, then long read at 4 loads PC, both FC=101; then execution starts.
REQ-018 Instructions SHALL be fetched one 16-bit word per cycle at PC (SIZE=10, FC=110), with PC += 2 per word.
REQ-019 Supported: NOP 4E71; MOVEQ #d8,Dn (sign-extended to 32); MOVE.B/W/L #imm,(xxx).L and MOVE.B/W/L Dn,(xxx).L.
REQ-020 BRA: BRA.B/BRA.W (60xx, disp 00 = word form) with target = opcode address + 2 + sign-extended displacement.
REQ-021 Illegal/unsupported opcode, BERRn low at termination, or address error SHALL halt: HALT_OUTn=0, bus idle, only reset exits.
REQ-022 HALT_INn low SHALL stall before the next S1; stalling never occurs mid-cycle.
REQ-023 BRn low SHALL, at the next cycle boundary, drive BGn=0 and BUS_EN=0 with strobes high; the bus is reclaimed once BRn and BGACKn are both high.
REQ-024 Interrupts SHALL not be serviced.

Reset
REQ-025 While RESET_IN=1: ASn=DSn=ECSn=OCSn=DBENn=1, RWn=1, ADR_OUT=0, DATA_OUT=0, DATA_EN=0, SIZE=00, FC_OUT=101, BUS_EN=1, BGn=1, HALT_OUTn=1, RESET_OUT=0.
REQ-026 While RESET_IN=1, D0-D7, A7 and PC SHALL be cleared, and asserting reset mid-cycle SHALL abort the cycle immediately.

Verification
REQ-027 mem[0]=00001000, mem[4]=00000008; release reset -> reads at 0x0 and 0x4 (SIZE 00, FC 101), then fetch at 0x8 (SIZE 10, FC 110).
REQ-028 13FC 0048 0000 0100 -> write ADR_OUT=0x100, SIZE=01, RWn=0, DATA_OUT=48484848.
REQ-029 7041, 33C0 0000 0102 -> D0=00000041, then write ADR_OUT=0x102, SIZE=10, DATA_OUT=00410041.
REQ-030 23FC 1234 5678 0000 0104 -> write ADR_OUT=0x104, SIZE=00, DATA_OUT=12345678; with DSACKn held 11 for 5 clocks, ASn stays low and nothing advances.
REQ-031 60FE -> repeated fetches at the same address; opcode FFFF or BERRn=0 -> HALT_OUTn=0 and no further ASn.
